sync_pattern_framer: RTL

//  Transmit-side framer: on START, emits a fixed C_PATTERN_WIDTH-bit sync word

---
 rtl/sync_pattern_framer_if.sv | 27 ++
 rtl/sync_pattern_framer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sync_pattern_framer_if.sv
// Handshake and serial-output bundle of the sync pattern framer.
// The master side requests frames and supplies payload words; the slave
// side (the framer) returns the serial stream and its status flags.
interface sync_pattern_framer_if #(
    parameter int C_DATA_WIDTH = 8
);
    logic                    START;
    logic [C_DATA_WIDTH-1:0] DIN;
    logic                    ND;
    logic                    RFD;
    logic                    DOUT;
    logic                    RDY;
    logic                    SOF;
    logic                    EOF;
    logic                    BUSY;
    logic                    UNDERRUN;

    modport master (
        output START, DIN, ND,
        input  RFD, DOUT, RDY, SOF, EOF, BUSY, UNDERRUN
    );

    modport slave (
        input  START, DIN, ND,
        output RFD, DOUT, RDY, SOF, EOF, BUSY, UNDERRUN
    );
endinterface

// File: rtl/sync_pattern_framer.sv
// Transmit-side framer: on START it sends a fixed sync word MSB first, then
// serializes C_PAYLOAD_WORDS payload words, each LSB first. A serial detector
// shifting new bits into its LSB sees C_PATTERN on the last sync bit.
// One payload word is buffered; it can be prefetched during the sync phase,
// and an empty buffer is bypassed so continuous ND gives a gap-free stream.
module sync_pattern_framer #(
    parameter int                         C_PATTERN_WIDTH = 16,
    parameter logic [C_PATTERN_WIDTH-1:0] C_PATTERN       = 16'hF628,
    parameter int                         C_DATA_WIDTH    = 8,
    parameter int                         C_PAYLOAD_WORDS = 2,
    parameter logic                       C_IDLE_BIT      = 1'b0
) (
    input logic                   CLK,
    input logic                   ARESETN,
    sync_pattern_framer_if.slave  bus
);
    localparam int PIDX_W = $clog2(C_PATTERN_WIDTH);
    localparam int BCNT_W = $clog2(C_DATA_WIDTH + 1);
    localparam int WCNT_W = $clog2(C_PAYLOAD_WORDS + 1);

    localparam logic [PIDX_W-1:0] PIDX_ONE   = PIDX_W'(1);
    localparam logic [PIDX_W-1:0] PIDX_START = PIDX_W'(C_PATTERN_WIDTH - 2);
    localparam logic [BCNT_W-1:0] BCNT_ONE   = BCNT_W'(1);
    localparam logic [BCNT_W-1:0] BCNT_FULL  = BCNT_W'(C_DATA_WIDTH);
    localparam logic [BCNT_W-1:0] BCNT_BYP   = BCNT_W'(C_DATA_WIDTH - 1);
    localparam logic [WCNT_W-1:0] WCNT_ONE   = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] WCNT_FULL  = WCNT_W'(C_PAYLOAD_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PAYLOAD
    } state_t;

    state_t                  state_q,      state_d;
    logic [PIDX_W-1:0]       pat_idx_q,    pat_idx_d;     // next sync bit to send
    logic [C_DATA_WIDTH-1:0] shreg_q,      shreg_d;       // buffered payload bits, LSB next
    logic [BCNT_W-1:0]       bitcnt_q,     bitcnt_d;      // bits held in shreg
    logic [WCNT_W-1:0]       words_left_q, words_left_d;  // words not yet accepted
    logic                    dout_q,       dout_d;
    logic                    rdy_q,        rdy_d;
    logic                    sof_q,        sof_d;
    logic                    eof_q,        eof_d;
    logic                    underrun_q,   underrun_d;

    logic rfd;
    logic take;

    // Ready-for-data is a pure decode of registered state, never of ND/DIN.
    always_comb begin
        rfd  = (state_q == ST_SYNC || state_q == ST_PAYLOAD) &&
               (bitcnt_q == '0) && (words_left_q != '0);
        take = bus.ND && rfd;
    end

    // Next-state and next-output decode for the IDLE -> SYNC -> PAYLOAD sequence.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        pat_idx_d    = pat_idx_q;
        shreg_d      = shreg_q;
        bitcnt_d     = bitcnt_q;
        words_left_d = words_left_q;
        dout_d       = C_IDLE_BIT;
        rdy_d        = 1'b0;
        sof_d        = 1'b0;
        eof_d        = 1'b0;
        underrun_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    state_d      = ST_SYNC;
                    pat_idx_d    = PIDX_START;
                    shreg_d      = '0;
                    bitcnt_d     = '0;
                    words_left_d = WCNT_FULL;
                    dout_d       = C_PATTERN[C_PATTERN_WIDTH-1];
                    rdy_d        = 1'b1;
                    sof_d        = 1'b1;
                end
            end

            ST_SYNC: begin
                dout_d = C_PATTERN[pat_idx_q];
                rdy_d  = 1'b1;
                if (pat_idx_q == '0) begin
                    state_d = ST_PAYLOAD;
                end else begin
                    pat_idx_d = pat_idx_q - PIDX_ONE;
                end
                // Prefetch the first payload word while the sync word drains.
                if (take) begin
                    shreg_d      = bus.DIN;
                    bitcnt_d     = BCNT_FULL;
                    words_left_d = words_left_q - WCNT_ONE;
                end
            end

            ST_PAYLOAD: begin
                if (bitcnt_q != '0) begin
                    dout_d   = shreg_q[0];
                    shreg_d  = shreg_q >> 1;
                    bitcnt_d = bitcnt_q - BCNT_ONE;
                    rdy_d    = 1'b1;
                    if (words_left_q == '0 && bitcnt_q == BCNT_ONE) begin
                        eof_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (take) begin
                    // Buffer empty but a word is offered: send its LSB directly
                    // so there is no bubble between words.
                    dout_d       = bus.DIN[0];
                    shreg_d      = bus.DIN >> 1;
                    bitcnt_d     = BCNT_BYP;
                    words_left_d = words_left_q - WCNT_ONE;
                    rdy_d        = 1'b1;
                    if (words_left_q == WCNT_ONE && C_DATA_WIDTH == 1) begin
                        eof_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    // Nothing to send: stall the frame without consuming a bit.
                    underrun_d = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset abandons any frame in progress.
    always_ff @(posedge CLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= ST_IDLE;
            pat_idx_q    <= '0;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            words_left_q <= '0;
            dout_q       <= C_IDLE_BIT;
            rdy_q        <= 1'b0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the same pre-edge values, independent of statement order.
            state_q      <= state_d;
            pat_idx_q    <= pat_idx_d;
            shreg_q      <= shreg_d;
            bitcnt_q     <= bitcnt_d;
            words_left_q <= words_left_d;
            dout_q       <= dout_d;
            rdy_q        <= rdy_d;
            sof_q        <= sof_d;
            eof_q        <= eof_d;
            underrun_q   <= underrun_d;
        end
    end

    assign bus.RFD      = rfd;
    assign bus.DOUT     = dout_q;
    assign bus.RDY      = rdy_q;
    assign bus.SOF      = sof_q;
    assign bus.EOF      = eof_q;
    assign bus.BUSY     = (state_q != ST_IDLE);
    assign bus.UNDERRUN = underrun_q;
endmodule
